// File: rtl/dut_result_tagger.sv
// Result tagger: buffers upstream results in a small FIFO, prefixes each accepted
// word with a wrapping sequence tag and presents it on a vld/busy output stream.
module dut_result_tagger #(
  parameter int unsigned DATA_W = 11,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEQ_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        din_busy,
  input  logic                        din_vld,
  input  logic [DATA_W-1:0]           din_data,
  input  logic                        dout_busy,
  output logic                        dout_vld,
  output logic [DATA_W+SEQ_W-1:0]     dout_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        seq_wrap
);

  localparam int unsigned OUT_W = DATA_W + SEQ_W;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             seq_wrap_q, seq_wrap_d;
  logic             push, pop;

  // Flow control is decoded from registered occupancy; no same-cycle bypass when full.
  assign din_busy  = (count_q == CNT_W'(DEPTH));
  assign dout_vld  = (count_q != '0);
  assign dout_data = dout_vld ? mem_q[rd_ptr_q] : '0;
  assign level     = count_q;
  assign seq_wrap  = seq_wrap_q;

  assign push = din_vld & ~din_busy;
  assign pop  = dout_vld & ~dout_busy;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    seq_wrap_d = push & (seq_q == {SEQ_W{1'b1}});
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      seq_d    = seq_q + SEQ_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      seq_wrap_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      seq_wrap_q <= seq_wrap_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {seq_q, din_data};
    end
  end

endmodule

// File: tb/tb_dut_result_tagger.sv
// Self-checking bench for dut_result_tagger: directed scenarios plus a randomized
// run checked against a queue-based model of the tagged FIFO.
module tb_dut_result_tagger;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_busy;
  logic        din_vld = 1'b0;
  logic [10:0] din_data = '0;
  logic        dout_busy = 1'b0;
  logic        dout_vld;
  logic [15:0] dout_data;
  logic [2:0]  level;
  logic        seq_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mq[$];
  int          exp_seq  = 0;
  bit          exp_wrap = 1'b0;

  dut_result_tagger dut (
    .clk      (clk),
    .rst      (rst),
    .din_busy (din_busy),
    .din_vld  (din_vld),
    .din_data (din_data),
    .dout_busy(dout_busy),
    .dout_vld (dout_vld),
    .dout_data(dout_data),
    .level    (level),
    .seq_wrap (seq_wrap)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and update the reference model from the driven inputs.
  task automatic tick();
    bit push, pop;
    @(posedge clk);
    push = din_vld && (mq.size() < DEPTH);
    pop  = !dout_busy && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    exp_wrap = push && (exp_seq == 31);
    if (push) begin
      mq.push_back({5'(exp_seq), din_data});
      exp_seq = (exp_seq + 1) % 32;
    end
    #1;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_seq  = 0;
    exp_wrap = 1'b0;
  endtask

  task automatic apply_reset();
    din_vld   = 1'b0;
    dout_busy = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (din_busy !== 1'b0) begin n_fail++; $display("FAIL reset_din_busy got %b exp 0", din_busy); end
    n_checks++; if (dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_dout_vld got %b exp 0", dout_vld); end
    n_checks++; if (dout_data !== 16'h0000) begin n_fail++; $display("FAIL reset_dout_data got %h exp 0000", dout_data); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++; if (seq_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_seq_wrap got %b exp 0", seq_wrap); end
  endtask

  task automatic test_single();
    apply_reset();
    din_vld = 1'b1; din_data = 11'h7F8;
    tick();
    din_vld = 1'b0;
    n_checks++; if (dout_vld !== 1'b1) begin n_fail++; $display("FAIL single_vld got %b exp 1", dout_vld); end
    n_checks++; if (dout_data !== 16'h07F8) begin n_fail++; $display("FAIL single_data got %h exp 07f8", dout_data); end
    n_checks++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", level); end
    tick();
    n_checks++; if (level !== 3'd0 || dout_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain got level %0d vld %b exp 0 0", level, dout_vld); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    dout_busy = 1'b1;
    din_vld   = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din_data = 11'(i);
      tick();
    end
    n_checks++; if (level !== 3'd4 || din_busy !== 1'b1) begin n_fail++; $display("FAIL bp_full got level %0d busy %b exp 4 1", level, din_busy); end
    din_data = 11'h005;
    tick(); tick();
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL bp_holdoff got level %0d exp 4", level); end
    n_checks++; if (dout_data !== 16'h0001) begin n_fail++; $display("FAIL bp_head0 got %h exp 0001", dout_data); end
    dout_busy = 1'b0;
    tick();
    n_checks++; if (level !== 3'd3 || din_busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got level %0d busy %b exp 3 0", level, din_busy); end
    n_checks++; if (dout_data !== 16'h0802) begin n_fail++; $display("FAIL bp_head1 got %h exp 0802", dout_data); end
    tick();
    din_vld = 1'b0;
    n_checks++; if (dout_data !== 16'h1003 || level !== 3'd3) begin n_fail++; $display("FAIL bp_head2 got %h lvl %0d exp 1003 3", dout_data, level); end
    tick();
    n_checks++; if (dout_data !== 16'h1804) begin n_fail++; $display("FAIL bp_head3 got %h exp 1804", dout_data); end
    tick();
    n_checks++; if (dout_data !== 16'h2005) begin n_fail++; $display("FAIL bp_head4 got %h exp 2005", dout_data); end
    tick();
    n_checks++; if (dout_vld !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL bp_empty got vld %b lvl %0d exp 0 0", dout_vld, level); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    dout_busy = 1'b1;
    din_vld   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_data = 11'($urandom);
      tick();
    end
    din_data = 11'h3AB;
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fp_lvl4 got %0d exp 4", level); end
    dout_busy = 1'b0;
    tick();
    dout_busy = 1'b1;
    n_checks++; if (level !== 3'd3 || din_busy !== 1'b0) begin n_fail++; $display("FAIL fp_lvl3 got lvl %0d busy %b exp 3 0", level, din_busy); end
    n_checks++; if (dout_data !== mq[0]) begin n_fail++; $display("FAIL fp_head got %h exp %h", dout_data, mq[0]); end
    tick();
    din_vld = 1'b0;
    n_checks++; if (level !== 3'd4 || din_busy !== 1'b1) begin n_fail++; $display("FAIL fp_relvl4 got lvl %0d busy %b exp 4 1", level, din_busy); end
    dout_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (dout_data !== mq[0]) begin n_fail++; $display("FAIL fp_drain%0d got %h exp %h", i, dout_data, mq[0]); end
      tick();
    end
    n_checks++; if (mq.size() != 0 || dout_vld !== 1'b0) begin n_fail++; $display("FAIL fp_final got vld %b exp 0", dout_vld); end
  endtask

  task automatic test_seq_wrap();
    logic [10:0] d;
    apply_reset();
    din_vld = 1'b1;
    for (int i = 0; i < 33; i++) begin
      d = 11'($urandom);
      din_data = d;
      tick();
      n_checks++; if (dout_data !== {5'(i % 32), d}) begin n_fail++; $display("FAIL wrap_tag%0d got %h exp %h", i, dout_data, {5'(i % 32), d}); end
      n_checks++; if (seq_wrap !== (i == 31)) begin n_fail++; $display("FAIL wrap_pulse%0d got %b exp %b", i, seq_wrap, (i == 31)); end
    end
    din_vld = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [10:0] d;
    apply_reset();
    dout_busy = 1'b1;
    din_vld   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_data = 11'($urandom);
      tick();
    end
    din_vld = 1'b0;
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL mid_lvl got %0d exp 3", level); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (level !== 3'd0 || dout_vld !== 1'b0 || dout_data !== 16'h0) begin n_fail++; $display("FAIL mid_async got lvl %0d vld %b data %h exp 0 0 0000", level, dout_vld, dout_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    tick();
    n_checks++; if (dout_vld !== 1'b0 || dout_data !== 16'h0) begin n_fail++; $display("FAIL mid_stale got vld %b data %h exp 0 0000", dout_vld, dout_data); end
    d = 11'h155;
    din_vld = 1'b1; din_data = d;
    tick();
    din_vld = 1'b0;
    n_checks++; if (dout_data !== {5'd0, d}) begin n_fail++; $display("FAIL mid_seq0 got %h exp %h", dout_data, {5'd0, d}); end
    dout_busy = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [15:0] exp_data;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      din_vld   = ($urandom_range(0, 9) < 7);
      din_data  = 11'($urandom);
      dout_busy = ($urandom_range(0, 9) < 4);
      tick();
      exp_data = (mq.size() != 0) ? mq[0] : 16'h0;
      n_checks++;
      if (dout_data !== exp_data || dout_vld !== (mq.size() != 0) ||
          din_busy !== (mq.size() == DEPTH) || level !== 3'(mq.size()) ||
          seq_wrap !== exp_wrap) begin
        n_fail++;
        $display("FAIL rand%0d got data %h vld %b busy %b lvl %0d wrap %b exp data %h lvl %0d wrap %b",
                 i, dout_data, dout_vld, din_busy, level, seq_wrap, exp_data, mq.size(), exp_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_full_pop();
    test_seq_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
